// File: rtl/s_term_loopback_cfg.sv
// South-edge termination: returns NUM_CH southbound wires northward, per-channel mode from config frames.
// Latency: mode0 tie-off, mode1 combinational, mode2 one cycle, mode3 DEPTH cycles; buffers are combinational.
// Backpressure: none; wires and frame strobes are free-running, every cycle is accepted.
module s_term_loopback_cfg #(
    parameter int NUM_CH          = 16,
    parameter int DEPTH           = 4,
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int CFG_FRAME_BASE  = 0
) (
    input  logic                       UserCLK,
    input  logic                       rst,
    output logic                       UserCLKo,
    output logic                       rsto,
    input  logic [FrameBitsPerRow-1:0] FrameData,
    output logic [FrameBitsPerRow-1:0] FrameData_O,
    input  logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
    input  logic [NUM_CH-1:0]          from_S,
    output logic [NUM_CH-1:0]          to_N,
    output logic                       cfg_wr
);

    localparam int CFG_FRAMES = (2 * NUM_CH + FrameBitsPerRow - 1) / FrameBitsPerRow;

    typedef enum logic [1:0] {
        MODE_TIE  = 2'd0,
        MODE_PASS = 2'd1,
        MODE_REG  = 2'd2,
        MODE_DLY  = 2'd3
    } mode_e;

    assign UserCLKo      = UserCLK;
    assign rsto          = rst;
    assign FrameData_O   = FrameData;
    assign FrameStrobe_O = FrameStrobe;

    logic [CFG_FRAMES-1:0] strobe_q;
    logic [CFG_FRAMES-1:0] cap;

    // strobe_q resets to ones so a strobe already high at reset release is not a rising edge
    assign cap = FrameStrobe[CFG_FRAME_BASE +: CFG_FRAMES] & ~strobe_q;

    always_ff @(posedge UserCLK) begin
        if (!rst) begin
            strobe_q <= '1;
            cfg_wr   <= 1'b0;
        end else begin
            strobe_q <= FrameStrobe[CFG_FRAME_BASE +: CFG_FRAMES];
            cfg_wr   <= |cap;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam int FI = (2 * c) / FrameBitsPerRow;
        localparam int BI = (2 * c) % FrameBitsPerRow;

        mode_e            mode_q;
        logic [DEPTH-1:0] pipe_q;
        logic             mode_chg;
        logic             ch_out;

        assign mode_chg = cap[FI] && (FrameData[BI +: 2] != mode_q);

        // pipe_q[0] is the one-cycle stage; pipe_q[DEPTH-1] is the tail of the delay line
        always_ff @(posedge UserCLK) begin
            if (!rst) begin
                mode_q <= MODE_TIE;
                pipe_q <= '0;
            end else begin
                if (cap[FI]) begin
                    mode_q <= mode_e'(FrameData[BI +: 2]);
                end
                if (mode_chg) begin
                    pipe_q <= '0;
                end else begin
                    pipe_q <= {pipe_q[DEPTH-2:0], from_S[c]};
                end
            end
        end

        always_comb begin
            ch_out = 1'b0;
            case (mode_q)
                MODE_TIE:  ch_out = 1'b0;
                MODE_PASS: ch_out = from_S[c];
                MODE_REG:  ch_out = pipe_q[0];
                default:   ch_out = pipe_q[DEPTH-1];
            endcase
        end

        assign to_N[c] = ch_out;
    end

endmodule

// File: tb/tb_s_term_loopback_cfg.sv
// Bench for s_term_loopback_cfg with 32 channels spread over config frames 3 and 4.
module tb_s_term_loopback_cfg;

    localparam int NUM_CH = 32;
    localparam int DEPTH  = 4;
    localparam int MFPC   = 20;
    localparam int FBPR   = 32;
    localparam int BASE   = 3;

    logic            UserCLK;
    logic            rst;
    logic            UserCLKo;
    logic            rsto;
    logic [FBPR-1:0] FrameData;
    logic [FBPR-1:0] FrameData_O;
    logic [MFPC-1:0] FrameStrobe;
    logic [MFPC-1:0] FrameStrobe_O;
    logic [31:0]     from_S;
    logic [31:0]     to_N;
    logic            cfg_wr;

    s_term_loopback_cfg #(
        .NUM_CH(NUM_CH), .DEPTH(DEPTH), .MaxFramesPerCol(MFPC),
        .FrameBitsPerRow(FBPR), .CFG_FRAME_BASE(BASE)
    ) dut (
        .UserCLK(UserCLK), .rst(rst), .UserCLKo(UserCLKo), .rsto(rsto),
        .FrameData(FrameData), .FrameData_O(FrameData_O),
        .FrameStrobe(FrameStrobe), .FrameStrobe_O(FrameStrobe_O),
        .from_S(from_S), .to_N(to_N), .cfg_wr(cfg_wr)
    );

    initial begin
        UserCLK = 1'b0;
        forever #5 UserCLK = ~UserCLK;
    end

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // Reference model: edge counter, input history, per-channel mode and last-clear edge.
    int          n = 0;
    logic [31:0] hist [0:2047];
    int          mode_m [NUM_CH];
    int          clr_m  [NUM_CH];
    logic [MFPC-1:0] sq_m = '1;
    logic        cfg_exp = 1'b0;

    function automatic logic [31:0] exp_to_n();
        logic [31:0] r;
        int k;
        r = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            case (mode_m[c])
                1: r[c] = from_S[c];
                2: if (n > clr_m[c]) r[c] = hist[n][c];
                3: begin
                    k = n - DEPTH + 1;
                    if (k > clr_m[c]) r[c] = hist[k][c];
                end
                default: r[c] = 1'b0;
            endcase
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_to_N"}, to_N, exp_to_n());
        check({tag, "_cfg_wr"}, {31'b0, cfg_wr}, {31'b0, cfg_exp});
        check({tag, "_fdata_o"}, FrameData_O, FrameData);
        check({tag, "_fstrb_o"}, {12'b0, FrameStrobe_O}, {12'b0, FrameStrobe});
        check({tag, "_rsto"}, {31'b0, rsto}, {31'b0, rst});
    endtask

    // Advance one clock edge: update the model with the inputs the DUT is about to sample.
    task automatic tick();
        logic [MFPC-1:0] rise;
        logic any;
        int f;
        logic [1:0] nm;
        n++;
        hist[n] = from_S;
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                mode_m[c] = 0;
                clr_m[c]  = n;
            end
            cfg_exp = 1'b0;
            sq_m    = '1;
        end else begin
            rise = FrameStrobe & ~sq_m;
            any  = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                f = BASE + (2 * c) / FBPR;
                if (rise[f]) begin
                    nm = FrameData[(2 * c) % FBPR +: 2];
                    if (int'(nm) != mode_m[c]) clr_m[c] = n;
                    mode_m[c] = int'(nm);
                    any = 1'b1;
                end
            end
            cfg_exp = any;
            sq_m    = FrameStrobe;
        end
        @(posedge UserCLK);
        #1;
    endtask

    initial begin
        for (int c = 0; c < NUM_CH; c++) begin
            mode_m[c] = 0;
            clr_m[c]  = 0;
        end
        rst = 1'b0; from_S = '1; FrameStrobe = '0; FrameData = 32'hA5A5_1234;
        tick(); tick();
        check_all("reset");
        check("reset_to_N_zero", to_N, 32'h0);
        FrameData = 32'h1357_9BDF; FrameStrobe = 20'h0F0F0;
        #1;
        check("reset_fdata_buf", FrameData_O, 32'h1357_9BDF);
        check("reset_fstrb_buf", {12'b0, FrameStrobe_O}, 32'h0F0F0);

        // Pass-through on all channels, written through both config frames at once
        FrameStrobe = '0; rst = 1'b1;
        tick(); check_all("release");
        FrameData = 32'h5555_5555; FrameStrobe = 20'h18;
        tick(); check_all("pt_cap");
        check("pt_cfg_pulse", {31'b0, cfg_wr}, 32'h1);
        FrameStrobe = '0;
        tick(); check_all("pt_cfg_off");
        check("pt_cfg_once", {31'b0, cfg_wr}, 32'h0);
        for (int i = 0; i < 16; i++) begin
            from_S = $urandom;
            #2; check_all("pt_comb");
            check("pt_direct", to_N, from_S);
            tick(); check_all("pt");
        end

        // Mixed: ch0 registered, ch1 delay line, all others tied off
        FrameData = 32'h0; FrameStrobe = 20'h10; tick();
        FrameStrobe = '0; tick();
        FrameData = 32'hE; FrameStrobe = 20'h08; tick(); check_all("mix_cap");
        FrameStrobe = '0; from_S = '0; tick(); tick(); check_all("mix_idle");
        from_S = 32'h3; tick(); check_all("mix1"); check("mix_d1", to_N, 32'h1);
        from_S = '0; tick(); check("mix_d2", to_N, 32'h0);
        tick(); check_all("mix3");
        tick(); check_all("mix4"); check("mix_d4", to_N, 32'h2);
        tick(); check("mix_d5", to_N, 32'h0);
        for (int i = 0; i < 24; i++) begin
            from_S = $urandom; tick(); check_all("mix_rnd");
        end

        // Flush: ch1 carries a 1 in the delay line when it is switched to registered
        from_S = 32'h2; tick();
        from_S = '0; tick();
        FrameData = 32'hA; FrameStrobe = 20'h08; tick(); check_all("flush_cap");
        FrameStrobe = '0;
        for (int i = 0; i < 5; i++) begin
            tick(); check_all("flush");
            check("flush_ch1", to_N & 32'h2, 32'h0);
        end

        // Rewriting an unchanged mode keeps in-flight data
        FrameData = 32'hE; FrameStrobe = 20'h08; tick();
        FrameStrobe = '0; from_S = 32'h2; tick();
        from_S = '0; FrameStrobe = 20'h08; tick(); check_all("keep_cap");
        FrameStrobe = '0; tick();
        tick(); check_all("keep"); check("keep_d4", to_N, 32'h2);

        // Reset while a bit is in flight
        from_S = 32'h2; tick();
        from_S = '0; rst = 1'b0; tick(); check_all("rst_mid");
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(); check("rst_mid_zero", to_N, 32'h0);
        end

        // Strobe held across reset release is not captured
        rst = 1'b0; FrameStrobe = 20'h08; FrameData = 32'h5555_5555; tick(); tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            from_S = $urandom; tick(); check_all("held");
            check("held_nocap", to_N, 32'h0);
        end
        FrameStrobe = '0; tick();
        FrameStrobe = 20'h08; tick(); check_all("reraise");
        check("reraise_cfg", {31'b0, cfg_wr}, 32'h1);
        FrameData = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            from_S = $urandom; tick(); check_all("held_long");
        end
        check("held_long_mode1", to_N & 32'hFFFF, from_S & 32'hFFFF);

        // Frames outside the config range are ignored
        FrameStrobe = 20'h81; FrameData = 32'h0; tick(); check_all("oor");
        check("oor_cfg", {31'b0, cfg_wr}, 32'h0);
        FrameStrobe = '0; tick(); check_all("oor_after");

        // Random traffic with occasional reset and random strobes on frames 0..7
        for (int i = 0; i < 300; i++) begin
            rst         = ($urandom_range(0, 49) != 0);
            FrameStrobe = 20'($urandom) & 20'h000FF;
            FrameData   = $urandom;
            from_S      = $urandom;
            tick(); check_all("rnd");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
